// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
//   Shared types and helpers for the program loader.
//   - state_t     : loader FSM states
//   - OP_RUN      : header opcode that releases the core
//   - OP_LOAD_MSK : header opcodes with these bits clear are region loads
//   - hdr*Lsb()   : bit offsets of the header fields for a given width
package prog_loader_pkg;

  typedef enum logic [2:0] {
    HDR,
    LOAD,
    RUN,
    DONE,
    ERR
  } state_t;

  localparam logic [3:0] OP_RUN      = 4'hF;
  localparam logic [3:0] OP_LOAD_MSK = 4'h8;

  // The opcode always occupies the top nibble of the stream word.
  function automatic int hdrOpLsb(input int dw);
    return dw - 4;
  endfunction

  // len_m1 sits directly above the base address field.
  function automatic int hdrLenLsb(input int aw);
    return aw;
  endfunction

  function automatic int hdrBaseLsb(input int aw);
    return 0 * aw;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if
//   valid/ready word stream carrying segment headers and payload.
//   Ports (signals):
//     valid : master -> slave, word present
//     ready : slave -> master, word taken when valid & ready
//     data  : master -> slave, header or payload word
interface prog_loader_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/prog_loader_run_monitor.sv
// prog_loader_run_monitor
//   Watches the core's data bus while the core runs.
//   Ports:
//     i_clk, i_rst   : clock, synchronous active-high reset
//     i_enable       : core is running (counter advances, compares armed)
//     i_mon_we/addr/wdata : core data-memory write bus
//     o_hit          : write to the tohost address this cycle
//     o_hit_pass     : written value equals 1
//     o_to_expired   : this cycle is the last one allowed by the timeout
//     o_cycles       : run cycles counted so far (saturating)
module prog_loader_run_monitor #(
  parameter int          ADDR_WIDTH     = 10,
  parameter int          DATA_WIDTH     = 32,
  parameter int unsigned TOHOST_ADDR    = 'h3FF,
  parameter int unsigned TIMEOUT_CYCLES = 500,
  parameter int          CYC_W          = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_mon_we,
  input  logic [ADDR_WIDTH-1:0] i_mon_addr,
  input  logic [DATA_WIDTH-1:0] i_mon_wdata,
  output logic                  o_hit,
  output logic                  o_hit_pass,
  output logic                  o_to_expired,
  output logic [CYC_W-1:0]      o_cycles
);

  logic [CYC_W-1:0] r_cycles;

  // Count every enabled cycle; hold at all-ones rather than wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cycles <= '0;
    end else if (i_enable && (r_cycles != '1)) begin
      r_cycles <= r_cycles + CYC_W'(1);
    end
  end

  // The counter increments at the end of the current cycle, so the
  // current cycle is the TIMEOUT_CYCLES-th one when it reads one less.
  always_comb begin
    o_hit        = i_enable && i_mon_we && (i_mon_addr == ADDR_WIDTH'(TOHOST_ADDR));
    o_hit_pass   = (i_mon_wdata == DATA_WIDTH'(1));
    o_to_expired = i_enable && (r_cycles >= CYC_W'(TIMEOUT_CYCLES - 1));
    o_cycles     = r_cycles;
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader
//   Boot/run controller: loads segments from a word stream into N_REGIONS
//   memories while holding the core in reset, then releases the core and
//   reports pass/fail from a tohost write or a cycle timeout.
//   Ports:
//     i_clk, i_rst      : clock, synchronous active-high reset
//     i_stream          : header/payload stream (slave side)
//     o_mem_we          : one-hot region write strobe (registered)
//     o_mem_addr/wdata  : shared write address/data (registered)
//     o_core_rst_n      : core reset, low while loading or finished
//     i_mon_we/addr/wdata : core data-memory write bus
//     o_done/o_pass/o_timeout : run outcome, sticky until reset
//     o_err             : malformed header seen, sticky until reset
//     o_cycles          : core cycles since release
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 10,
  parameter int          DATA_WIDTH     = 32,
  parameter int          N_REGIONS      = 2,
  parameter int unsigned TOHOST_ADDR    = 'h3FF,
  parameter int unsigned TIMEOUT_CYCLES = 500,
  parameter int          CYC_W          = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  prog_loader_if.slave          i_stream,
  output logic [N_REGIONS-1:0]  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_core_rst_n,
  input  logic                  i_mon_we,
  input  logic [ADDR_WIDTH-1:0] i_mon_addr,
  input  logic [DATA_WIDTH-1:0] i_mon_wdata,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_timeout,
  output logic                  o_err,
  output logic [CYC_W-1:0]      o_cycles
);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] r_rem;
  logic [2:0]            r_region;
  logic [N_REGIONS-1:0]  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_pass;
  logic                  r_timeout;

  logic                  w_ready;
  logic                  w_accept;
  logic [3:0]            w_op;
  logic [ADDR_WIDTH-1:0] w_len;
  logic [ADDR_WIDTH-1:0] w_base;
  logic                  w_is_load;
  logic                  w_region_ok;
  logic [N_REGIONS-1:0]  w_region_we;
  logic                  w_running;
  logic                  w_hit;
  logic                  w_hit_pass;
  logic                  w_expired;
  logic                  w_unused;

  // Header field extraction; the bits between len_m1 and the opcode carry
  // nothing and are only folded into w_unused.
  assign w_op        = i_stream.data[hdrOpLsb(DATA_WIDTH) +: 4];
  assign w_len       = i_stream.data[hdrLenLsb(ADDR_WIDTH) +: ADDR_WIDTH];
  assign w_base      = i_stream.data[hdrBaseLsb(ADDR_WIDTH) +: ADDR_WIDTH];
  assign w_is_load   = ((w_op & OP_LOAD_MSK) == 4'h0);
  assign w_region_ok = ({1'b0, w_op[2:0]} < 4'(N_REGIONS));
  assign w_accept    = i_stream.valid && w_ready;
  assign w_running   = (r_state == RUN);
  assign w_unused    = &{1'b0, i_stream.data};

  prog_loader_run_monitor #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .TOHOST_ADDR   (TOHOST_ADDR),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CYC_W         (CYC_W)
  ) u_monitor (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_enable    (w_running),
    .i_mon_we    (i_mon_we),
    .i_mon_addr  (i_mon_addr),
    .i_mon_wdata (i_mon_wdata),
    .o_hit       (w_hit),
    .o_hit_pass  (w_hit_pass),
    .o_to_expired(w_expired),
    .o_cycles    (o_cycles)
  );

  // Decode the latched region number into the one-hot write strobe.
  always_comb begin
    w_region_we = '0;
    for (int r = 0; r < N_REGIONS; r++) begin
      w_region_we[r] = (r_region == 3'(r));
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= HDR;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and state-decoded outputs. in_ready is also forced low
  // while reset is asserted so every output reads 0 during reset.
  always_comb begin
    w_next       = r_state;
    w_ready      = 1'b0;
    o_core_rst_n = 1'b0;
    o_done       = 1'b0;
    o_err        = 1'b0;
    unique case (r_state)
      HDR: begin
        w_ready = !i_rst;
        if (w_accept) begin
          if (w_is_load && w_region_ok) begin
            w_next = LOAD;
          end else if (w_op == OP_RUN) begin
            w_next = RUN;
          end else begin
            w_next = ERR;
          end
        end
      end
      LOAD: begin
        w_ready = !i_rst;
        if (w_accept && (r_rem == '0)) begin
          w_next = HDR;
        end
      end
      RUN: begin
        o_core_rst_n = 1'b1;
        if (w_hit || w_expired) begin
          w_next = DONE;
        end
      end
      DONE: begin
        o_done = 1'b1;
      end
      ERR: begin
        o_err = 1'b1;
      end
      default: begin
        w_next = HDR;
      end
    endcase
  end

  assign i_stream.ready = w_ready;

  // Segment pointer, registered memory write port and run outcome.
  // The write strobe defaults low each cycle so it lasts exactly one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr       <= '0;
      r_rem       <= '0;
      r_region    <= '0;
      r_mem_we    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_mem_we <= '0;
      if ((r_state == HDR) && w_accept) begin
        r_ptr    <= w_base;
        r_rem    <= w_len;
        r_region <= w_op[2:0];
      end
      if ((r_state == LOAD) && w_accept) begin
        r_mem_we    <= w_region_we;
        r_mem_addr  <= r_ptr;
        r_mem_wdata <= i_stream.data;
        r_ptr       <= r_ptr + ADDR_WIDTH'(1);
        r_rem       <= r_rem - ADDR_WIDTH'(1);
      end
      // A tohost write takes priority over a timeout landing on the same cycle.
      if (r_state == RUN) begin
        if (w_hit) begin
          r_pass    <= w_hit_pass;
          r_timeout <= 1'b0;
        end else if (w_expired) begin
          r_pass    <= 1'b0;
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_pass      = r_pass;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
//   Self-checking bench for prog_loader: memory writes are predicted into a
//   scoreboard queue when payload is sent and checked as the DUT emits them.
module tb_prog_loader;

  logic        clk;
  logic        rst;
  logic        monWe;
  logic [9:0]  monAddr;
  logic [31:0] monWdata;
  logic [1:0]  memWe;
  logic [9:0]  memAddr;
  logic [31:0] memWdata;
  logic        coreRstN;
  logic        done;
  logic        pass;
  logic        timeoutFlag;
  logic        err;
  logic [31:0] cycles;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;
  bit monOn       = 0;

  typedef struct {
    logic [1:0]  we;
    logic [9:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t sbq[$];

  prog_loader_if #(.DATA_WIDTH(32)) stream ();

  prog_loader dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_stream    (stream),
    .o_mem_we    (memWe),
    .o_mem_addr  (memAddr),
    .o_mem_wdata (memWdata),
    .o_core_rst_n(coreRstN),
    .i_mon_we    (monWe),
    .i_mon_addr  (monAddr),
    .i_mon_wdata (monWdata),
    .o_done      (done),
    .o_pass      (pass),
    .o_timeout   (timeoutFlag),
    .o_err       (err),
    .o_cycles    (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every write the DUT emits must match the oldest prediction, in the cycle
  // right after its payload word was accepted.
  always @(negedge clk) begin
    wr_t e;
    if (monOn && (memWe !== 2'b00)) begin
      testsRun++;
      if (sbq.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL spurious_write we=%b addr=%h data=%h, expected no write", memWe, memAddr, memWdata);
      end else begin
        e = sbq.pop_front();
        if ({memWe, memAddr, memWdata} !== {e.we, e.addr, e.data} || cyc != e.cyc) begin
          testsFailed++;
          $display("[TB] FAIL mem_write got we=%b addr=%h data=%h cyc=%0d, expected we=%b addr=%h data=%h cyc=%0d",
                   memWe, memAddr, memWdata, cyc, e.we, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  function automatic logic [31:0] mkHdr(input logic [3:0] op, input logic [9:0] len, input logic [9:0] base);
    return {op, 8'h00, len, base};
  endfunction

  // Present one word for one cycle; caller sits #1 after a rising edge.
  task automatic sendWord(input logic [31:0] w, input bit isPayload, input logic [1:0] expWe, input logic [9:0] expAddr);
    stream.valid = 1'b1;
    stream.data  = w;
    @(posedge clk);
    #1;
    if (isPayload) sbq.push_back('{we: expWe, addr: expAddr, data: w, cyc: cyc});
  endtask

  task automatic doReset();
    rst          = 1'b1;
    stream.valid = 1'b0;
    monWe        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    stream.valid = 1'b0;
    stream.data  = '0;
    monWe        = 1'b0;
    monAddr      = '0;
    monWdata     = '0;
    @(posedge clk);
    @(negedge clk);
    monOn = 1;
    testsRun++;
    if ({stream.ready, memWe, coreRstN, done, pass, timeoutFlag, err, cycles} !== 40'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs got rdy=%b we=%b crn=%b done=%b pass=%b to=%b err=%b cyc=%0d, expected all 0",
               stream.ready, memWe, coreRstN, done, pass, timeoutFlag, err, cycles);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    testsRun++;
    if (stream.ready !== 1'b1 || coreRstN !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL after_reset got ready=%b core_rst_n=%b, expected 1 0", stream.ready, coreRstN);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_load();
    sendWord(mkHdr(4'h0, 10'd3, 10'h000), 0, 2'b00, 10'h0);
    for (int i = 0; i < 4; i++) sendWord(32'hA5A5_0000 + i, 1, 2'b01, 10'(i));
    sendWord(mkHdr(4'h1, 10'd2, 10'h3FE), 0, 2'b00, 10'h0);
    sendWord(32'h1111_0001, 1, 2'b10, 10'h3FE);
    sendWord(32'h1111_0002, 1, 2'b10, 10'h3FF);
    testsRun++;
    if (stream.ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL load_ready got %b, expected 1", stream.ready);
    end
    sendWord(32'h1111_0003, 1, 2'b10, 10'h000);
    stream.valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    testsRun++;
    if (sbq.size() != 0 || coreRstN !== 1'b0 || stream.ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL load_drain got pending=%0d crn=%b ready=%b, expected 0 0 1", sbq.size(), coreRstN, stream.ready);
    end
  endtask

  // Runs the core for up to lastCycle run cycles; tohost write of hitData at lastCycle.
  task automatic runToHost(input int lastCycle, input logic [31:0] hitData, input string name,
                           input logic expPass);
    sendWord(mkHdr(4'hF, 10'd0, 10'd0), 0, 2'b00, 10'h0);
    stream.valid = 1'b0;
    testsRun++;
    if (coreRstN !== 1'b1 || stream.ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL %s_release got crn=%b ready=%b, expected 1 0", name, coreRstN, stream.ready);
    end
    for (int n = 1; n <= lastCycle; n++) begin
      monWe = 1'b0;
      if (n == 5) begin
        monWe = 1'b1; monAddr = 10'h010; monWdata = 32'd5;
      end
      if (n == lastCycle) begin
        monWe = 1'b1; monAddr = 10'h3FF; monWdata = hitData;
      end
      @(posedge clk);
      #1;
      if (n == lastCycle - 1) begin
        testsRun++;
        if (done !== 1'b0 || cycles !== 32'(n)) begin
          testsFailed++;
          $display("[TB] FAIL %s_early got done=%b cycles=%0d, expected 0 %0d", name, done, cycles, n);
        end
      end
    end
    monWe = 1'b0;
    testsRun++;
    if ({done, pass, timeoutFlag, coreRstN} !== {1'b1, expPass, 1'b0, 1'b0} || cycles !== 32'(lastCycle)) begin
      testsFailed++;
      $display("[TB] FAIL %s_done got done=%b pass=%b to=%b crn=%b cycles=%0d, expected 1 %b 0 0 %0d",
               name, done, pass, timeoutFlag, coreRstN, cycles, expPass, lastCycle);
    end
    repeat (3) @(posedge clk);
    #1;
    testsRun++;
    if (cycles !== 32'(lastCycle) || done !== 1'b1 || stream.ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL %s_frozen got cycles=%0d done=%b ready=%b, expected %0d 1 0",
               name, cycles, done, stream.ready, lastCycle);
    end
  endtask

  task automatic test_run_pass();
    runToHost(40, 32'd1, "run_pass", 1'b1);
    doReset();
    runToHost(20, 32'd3, "run_fail_value", 1'b0);
  endtask

  task automatic test_timeout();
    doReset();
    sendWord(mkHdr(4'hF, 10'd0, 10'd0), 0, 2'b00, 10'h0);
    stream.valid = 1'b0;
    for (int n = 1; n <= 500; n++) begin
      @(posedge clk);
      #1;
      if (n == 499) begin
        testsRun++;
        if (done !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL timeout_early got done=%b at cycle 499, expected 0", done);
        end
      end
    end
    testsRun++;
    if ({done, pass, timeoutFlag, coreRstN} !== 4'b1010 || cycles !== 32'd500) begin
      testsFailed++;
      $display("[TB] FAIL timeout_done got done=%b pass=%b to=%b crn=%b cycles=%0d, expected 1 0 1 0 500",
               done, pass, timeoutFlag, coreRstN, cycles);
    end
    doReset();
    runToHost(500, 32'd1, "tohost_at_timeout", 1'b1);
  endtask

  task automatic test_error();
    doReset();
    sendWord(mkHdr(4'h5, 10'd0, 10'd0), 0, 2'b00, 10'h0);
    stream.valid = 1'b0;
    testsRun++;
    if ({err, stream.ready, coreRstN, done} !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL bad_region got err=%b ready=%b crn=%b done=%b, expected 1 0 0 0", err, stream.ready, coreRstN, done);
    end
    doReset();
    testsRun++;
    if (err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL err_cleared got %b, expected 0", err);
    end
    sendWord(mkHdr(4'h8, 10'd0, 10'd0), 0, 2'b00, 10'h0);
    stream.valid = 1'b0;
    testsRun++;
    if (err !== 1'b1 || stream.ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL bad_opcode got err=%b ready=%b, expected 1 0", err, stream.ready);
    end
    doReset();
    // Abort a 4-word load after two words.
    sendWord(mkHdr(4'h0, 10'd3, 10'h100), 0, 2'b00, 10'h0);
    sendWord(32'hDEAD_0000, 1, 2'b01, 10'h100);
    sendWord(32'hDEAD_0001, 1, 2'b01, 10'h101);
    doReset();
    repeat (4) @(posedge clk);
    #1;
    testsRun++;
    if (stream.ready !== 1'b1 || sbq.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL abort_load got ready=%b pending=%0d, expected 1 0", stream.ready, sbq.size());
    end
    // Valid gaps inside a load must not produce writes or move the pointer.
    sendWord(mkHdr(4'h1, 10'd1, 10'h020), 0, 2'b00, 10'h0);
    sendWord(32'hCAFE_0000, 1, 2'b10, 10'h020);
    stream.valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sendWord(32'hCAFE_0001, 1, 2'b10, 10'h021);
    stream.valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    testsRun++;
    if (sbq.size() != 0 || stream.ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL gap_load got pending=%0d ready=%b, expected 0 1", sbq.size(), stream.ready);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_run_pass();
    test_timeout();
    test_error();
    repeat (2) @(posedge clk);
    testsRun++;
    if (sbq.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_empty got %0d pending writes, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
